// File: rtl/vram_frame_scanner.sv
// Scans a 128x96 1-bpp bitmap out of the FRAMEn VRAMs, upscaled to 640x480.
// Two-tick pipeline: address/sync capture, then colour/sync output. Also steps frame_sel for animation.
module vram_frame_scanner #(
  parameter int          H_VISIBLE  = 640,
  parameter int          H_TOTAL    = 800,
  parameter int          V_VISIBLE  = 480,
  parameter int          V_TOTAL    = 525,
  parameter int          SCALE      = 5,
  parameter int          NUM_FRAMES = 6,
  parameter int          FRAME_HOLD = 8,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_tick,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        anim_enable,
  input  logic        pixel_val,
  output logic [13:0] address,
  output logic        read_enable,
  output logic        reg_enable,
  output logic [1:0]  write_enable,
  output logic [2:0]  frame_sel,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);
  localparam int         SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int         HW      = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [6:0] COL_MAX = 7'(H_VISIBLE / SCALE - 1);
  localparam logic [6:0] ROW_MAX = 7'(V_VISIBLE / SCALE - 1);

  typedef struct packed {
    logic vo;
    logic hs;
    logic vs;
  } sync_t;

  logic [SW-1:0] xsub, xsub_nxt, ysub;
  logic [6:0]    col, col_nxt, row;
  logic [HW-1:0] vid_cnt;
  sync_t         s1;
  logic          line_end, blank_start;

  assign line_end    = h_count == 10'(H_TOTAL - 1);
  assign blank_start = (h_count == 10'd0) && (v_count == 10'(V_VISIBLE));

  // The address for this tick must already reflect this tick's h_count, hence the look-ahead.
  always_comb begin
    xsub_nxt = xsub;
    col_nxt  = col;
    if (h_count == 10'd0) begin
      xsub_nxt = '0;
      col_nxt  = '0;
    end else if (xsub == SW'(SCALE - 1)) begin
      xsub_nxt = '0;
      if (col != COL_MAX) col_nxt = col + 7'd1;
    end else begin
      xsub_nxt = xsub + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xsub <= '0;
      col  <= '0;
      ysub <= '0;
      row  <= '0;
    end else if (pixel_tick) begin
      xsub <= xsub_nxt;
      col  <= col_nxt;
      if (line_end) begin
        if (v_count == 10'(V_TOTAL - 1)) begin
          ysub <= '0;
          row  <= '0;
        end else if (v_count < 10'(V_VISIBLE)) begin
          if (ysub == SW'(SCALE - 1)) begin
            ysub <= '0;
            if (row != ROW_MAX) row <= row + 7'd1;
          end else begin
            ysub <= ysub + SW'(1);
          end
        end
      end
    end
  end

  // read_enable is a one-clk strobe, so it is the only thing updated off-tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      address     <= '0;
      read_enable <= 1'b0;
      s1          <= '{vo: 1'b0, hs: 1'b1, vs: 1'b1};
      rgb         <= 12'h000;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
    end else begin
      read_enable <= pixel_tick & video_on;
      if (pixel_tick) begin
        address   <= {row, col_nxt};
        s1        <= '{vo: video_on, hs: hsync_in, vs: vsync_in};
        rgb       <= s1.vo ? (pixel_val ? FG_COLOR : BG_COLOR) : 12'h000;
        hsync_out <= s1.hs;
        vsync_out <= s1.vs;
      end
    end
  end

  // Frame stepping happens only at the start of vertical blanking, so no tearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_cnt   <= '0;
      frame_sel <= '0;
    end else if (pixel_tick && blank_start && anim_enable) begin
      if (vid_cnt == HW'(FRAME_HOLD - 1)) begin
        vid_cnt   <= '0;
        frame_sel <= (frame_sel == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame_sel + 3'd1;
      end else begin
        vid_cnt <= vid_cnt + HW'(1);
      end
    end
  end

  assign reg_enable   = 1'b0;
  assign write_enable = 2'b00;
endmodule

// File: tb/tb_vram_frame_scanner.sv
// Bench for vram_frame_scanner: behavioural VRAM + arithmetic model, per-cycle compare, literal pins.
module tb_vram_frame_scanner;
  logic        clk, reset, pixel_tick, video_on, hsync_in, vsync_in, anim_enable, pixel_val;
  logic [9:0]  h_count, v_count;
  logic [13:0] address;
  logic        read_enable, reg_enable;
  logic [1:0]  write_enable;
  logic [2:0]  frame_sel;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  int checks = 0;
  int errors = 0;

  logic vram [0:5][0:16383];

  // Model: counts of ticks since line start / lines since frame start, divided down by SCALE.
  int          m_coln, m_rown, m_vid, m_fs, s1_fs;
  logic [13:0] m_addr, s1_addr;
  logic        m_re, m_hs, m_vs, s1_vo, s1_hs, s1_vs;
  logic [11:0] m_rgb;

  logic        rd_pend;
  logic [13:0] pend_addr;
  int          pend_fs;

  vram_frame_scanner dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .h_count(h_count), .v_count(v_count),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in), .anim_enable(anim_enable),
    .pixel_val(pixel_val), .address(address), .read_enable(read_enable), .reg_enable(reg_enable),
    .write_enable(write_enable), .frame_sel(frame_sel), .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int rgap();
    return int'($urandom_range(2, 4));
  endfunction

  task automatic model_reset();
    m_coln = 0; m_rown = 0; m_vid = 0; m_fs = 0;
    m_addr = '0; m_re = 1'b0; m_rgb = '0; m_hs = 1'b1; m_vs = 1'b1;
    s1_vo = 1'b0; s1_hs = 1'b1; s1_vs = 1'b1; s1_addr = '0; s1_fs = 0;
  endtask

  task automatic model_tick(input int h, input int v, input logic vo, input logic hs, input logic vs);
    m_coln = (h == 0) ? 0 : m_coln + 1;
    m_addr = 14'(imin(m_rown / 5, 95) * 128 + imin(m_coln / 5, 127));
    if (h == 799) begin
      if (v == 524) m_rown = 0;
      else if (v < 480) m_rown++;
    end
    m_rgb = s1_vo ? (vram[s1_fs][s1_addr] ? 12'hFFF : 12'h000) : 12'h000;
    m_hs  = s1_hs;
    m_vs  = s1_vs;
    if (h == 0 && v == 480 && anim_enable) begin
      if (m_vid == 7) begin
        m_vid = 0;
        m_fs  = (m_fs + 1) % 6;
      end else m_vid++;
    end
    s1_vo = vo; s1_hs = hs; s1_vs = vs; s1_addr = m_addr; s1_fs = m_fs;
    m_re  = vo;
  endtask

  // One clk of stimulus: the VRAM answers a read one clk after read_enable, otherwise holds.
  task automatic step(input logic tk, input int h, input int v);
    logic vo, hs, vs;
    @(negedge clk);
    if (rd_pend) pixel_val = vram[pend_fs][pend_addr];
    else if (!s1_vo) pixel_val = 1'b1;
    rd_pend    = read_enable;
    pend_addr  = address;
    pend_fs    = int'(frame_sel);
    pixel_tick = tk;
    m_re       = 1'b0;
    if (tk) begin
      vo = (h < 640) && (v < 480);
      hs = !(h >= 656 && h < 752);
      vs = !(v >= 490 && v < 492);
      h_count = 10'(h); v_count = 10'(v);
      video_on = vo; hsync_in = hs; vsync_in = vs;
      model_tick(h, v, vo, hs, vs);
    end
  endtask

  task automatic tick(input int h, input int v, input int gap);
    for (int i = 1; i < gap; i++) step(1'b0, h, v);
    step(1'b1, h, v);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    pixel_tick = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    rd_pend = 1'b0;
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_hsync", 32'(hsync_out), 32'h1);
    chk("rst_vsync", 32'(vsync_out), 32'h1);
    chk("rst_frame_sel", 32'(frame_sel), 32'h0);
    chk("rst_address", 32'(address), 32'h0);
    chk("rst_read_enable", 32'(read_enable), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("address", 32'(address), 32'(m_addr));
      chk("read_enable", 32'(read_enable), 32'(m_re));
      chk("frame_sel", 32'(frame_sel), 32'(m_fs));
      chk("rgb", 32'(rgb), 32'(m_rgb));
      chk("hsync_out", 32'(hsync_out), 32'(m_hs));
      chk("vsync_out", 32'(vsync_out), 32'(m_vs));
      chk("reg_enable", 32'(reg_enable), 32'h0);
      chk("write_enable", 32'(write_enable), 32'h0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int col_seq [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    reset = 1'b0; pixel_tick = 1'b0; h_count = '0; v_count = '0; video_on = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; anim_enable = 1'b0; pixel_val = 1'b0;
    rd_pend = 1'b0; pend_addr = '0; pend_fs = 0;
    model_reset();
    for (int f = 0; f < 6; f++)
      for (int a = 0; a < 16384; a++) vram[f][a] = 1'($urandom);
    vram[0][2] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Line 0: column scaling, read strobes, colour and sync alignment, blanking.
    for (int h = 0; h < 10; h++) begin
      tick(h, 0, 4);
      chk("col_seq", 32'(address), 32'(col_seq[h]));
      chk("re_pulse", 32'(read_enable), 32'h1);
    end
    for (int h = 10; h < 800; h++) begin
      tick(h, 0, rgap());
      if (h == 11 || h == 12) chk("rgb_fg", 32'(rgb), 32'hFFF);
      if (h == 11) chk("hsync_align", 32'(hsync_out), 32'h1);
      if (h == 656) chk("hsync_pre", 32'(hsync_out), 32'h1);
      if (h == 657) chk("hsync_low", 32'(hsync_out), 32'h0);
      if (h == 640) chk("re_blank", 32'(read_enable), 32'h0);
      if (h == 641) chk("rgb_blank", 32'(rgb), 32'h0);
    end

    // Rest of frame: sparse lines, with full lines where row boundaries are pinned.
    for (int v = 1; v < 525; v++) begin
      if (v == 5 || v == 479) begin
        for (int h = 0; h < 800; h++) begin
          tick(h, v, int'($urandom_range(2, 3)));
          if (h == 639 && v == 5) chk("addr_row1_col127", 32'(address), 32'd255);
          if (h == 639 && v == 479) chk("addr_last", 32'(address), 32'd12287);
        end
      end else begin
        tick(0, v, 2);
        tick(int'($urandom_range(1, 798)), v, 2);
        tick(799, v, 2);
      end
    end
    chk("frame_sel_held", 32'(frame_sel), 32'h0);

    // Animation over compressed frames; enable is dropped for frames 21..25.
    for (int f = 1; f <= 61; f++) begin
      anim_enable = !(f >= 21 && f <= 25);
      for (int k = 0; k < 3; k++)
        tick(int'($urandom_range(1, 639)), int'($urandom_range(0, 479)), rgap());
      tick(0, 480, rgap());
      tick(799, 524, rgap());
      if (f == 8)  chk("anim_first_step", 32'(frame_sel), 32'h1);
      if (f == 25) chk("anim_hold", 32'(frame_sel), 32'h2);
      if (f == 53) chk("anim_wrap", 32'(frame_sel), 32'h0);
      if (f == 61) chk("anim_after_wrap", 32'(frame_sel), 32'h1);
    end

    // Reset mid-line, then resync at the next line start.
    for (int h = 0; h <= 300; h++) tick(h, 10, rgap());
    do_reset();
    for (int h = 301; h < 800; h++) begin
      tick(h, 10, rgap());
      if (h == 301) chk("post_rst_addr", 32'(address), 32'h0);
    end
    for (int h = 0; h < 6; h++) begin
      tick(h, 11, rgap());
      if (h == 0) chk("resync_col0", 32'(address), 32'h0);
      if (h == 5) chk("resync_col1", 32'(address), 32'h1);
    end

    repeat (4) step(1'b0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
